tank_cmd_arbiter: RTL and testbench

//  Shares one tank move/fire update engine among N_TANKS command sources
//  (player pad, autonomous tank drivers). Sources present 5-bit commands
//  {fire, left, up, right, down}. Per frame tick, each tank is granted at most once.

---
 rtl/tank_cmd_arbiter.sv | 150 +++++++++++++++
 tb/tb_tank_cmd_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tank_cmd_arbiter.sv
// tank_cmd_arbiter
//   Shares one tank move/fire update engine among N_TANKS command sources.
//   Each frame (delimited by tick) every tank is granted at most once.
//   Winners are picked round-robin. Commands are sanitized before issue:
//   more than one direction bit clears the move, and an active fire
//   cooldown clears the fire bit. Non-empty commands go to the engine over
//   valid/ready. Empty commands are dropped and acknowledged immediately.
// Ports
//   clk, reset  clock; synchronous active-high reset
//   tick        one-cycle frame pulse; clears served bits, ages cooldowns
//   req         per-tank request level
//   cmd_flat    tank i command at [5i+4:5i] = {fire, left, up, right, down}
//   ack         one-cycle pulse when tank i's command is issued or dropped
//   eng_valid   command to engine valid
//   eng_ready   engine accept; transfer on eng_valid & eng_ready
//   eng_id      tank index of eng_cmd
//   eng_cmd     sanitized command
//   busy        high while a command is waiting for the engine
module tank_cmd_arbiter #(
  parameter int unsigned N_TANKS       = 4,
  parameter int unsigned ID_W          = 2,
  parameter int unsigned FIRE_COOLDOWN = 8,
  parameter int unsigned CD_W          = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [N_TANKS-1:0]   req,
  input  logic [5*N_TANKS-1:0] cmd_flat,
  output logic [N_TANKS-1:0]   ack,
  output logic                 eng_valid,
  input  logic                 eng_ready,
  output logic [ID_W-1:0]      eng_id,
  output logic [4:0]           eng_cmd,
  output logic                 busy
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state, state_next;
  logic [N_TANKS-1:0]  served;
  logic [CD_W-1:0]     cooldown [N_TANKS];
  logic [ID_W-1:0]     rr_ptr;

  logic [N_TANKS-1:0]  elig;
  logic                found;
  logic [ID_W-1:0]     win;
  logic [4:0]          win_cmd;
  logic                win_cd_zero;
  logic [4:0]          san_cmd;
  logic                start_issue;
  logic                drop;
  logic                xfer;
  logic [N_TANKS-1:0]  consumed;

  // Round-robin winner search starting just after rr_ptr.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    elig  = req & ~served;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 1; k <= N_TANKS; k++) begin
      idx = (32'(rr_ptr) + k) % N_TANKS;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  // Winner command and sanitization.
  always_comb begin
    win_cmd     = '0;
    win_cd_zero = 1'b1;
    for (int unsigned i = 0; i < N_TANKS; i++) begin
      if (ID_W'(i) == win) begin
        win_cmd     = cmd_flat[5*i +: 5];
        win_cd_zero = (cooldown[i] == '0);
      end
    end
    san_cmd[3:0] = (|(win_cmd[3:0] & (win_cmd[3:0] - 4'd1))) ? 4'b0000 : win_cmd[3:0];
    san_cmd[4]   = win_cmd[4] & win_cd_zero;
  end

  // FSM next-state and outputs.
  always_comb begin
    state_next  = state;
    start_issue = 1'b0;
    drop        = 1'b0;
    xfer        = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          if (san_cmd != '0) begin
            start_issue = 1'b1;
            state_next  = ISSUE;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (eng_ready) begin
          xfer       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    for (int unsigned i = 0; i < N_TANKS; i++) begin
      consumed[i] = (drop && (win == ID_W'(i))) || (xfer && (eng_id == ID_W'(i)));
    end
    eng_valid = (state == ISSUE);
    busy      = (state == ISSUE);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack     <= '0;
      eng_id  <= '0;
      eng_cmd <= '0;
      served  <= '0;
      rr_ptr  <= ID_W'(N_TANKS - 1);
      for (int unsigned i = 0; i < N_TANKS; i++) cooldown[i] <= '0;
    end else begin
      ack <= consumed;
      if (start_issue) begin
        eng_id  <= win;
        eng_cmd <= san_cmd;
      end
      if (xfer) rr_ptr <= eng_id;
      // The tank consumed this cycle stays served even when tick clears the rest.
      served <= (tick ? '0 : served) | consumed;
      // A cooldown load takes priority over the tick decrement.
      for (int unsigned i = 0; i < N_TANKS; i++) begin
        if (xfer && eng_cmd[4] && (eng_id == ID_W'(i)))
          cooldown[i] <= CD_W'(FIRE_COOLDOWN);
        else if (tick && (cooldown[i] != '0))
          cooldown[i] <= cooldown[i] - CD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tank_cmd_arbiter.sv
module tb_tank_cmd_arbiter;
  localparam int N  = 4;
  localparam int FC = 8;

  logic        clk = 1'b0;
  logic        r_reset, r_tick, r_ready;
  logic [3:0]  r_req;
  logic [19:0] r_cmd;
  logic [3:0]  ack;
  logic        eng_valid, busy;
  logic [1:0]  eng_id;
  logic [4:0]  eng_cmd;

  tank_cmd_arbiter #(.N_TANKS(4), .ID_W(2), .FIRE_COOLDOWN(8), .CD_W(4)) dut (
    .clk(clk), .reset(r_reset), .tick(r_tick), .req(r_req), .cmd_flat(r_cmd),
    .ack(ack), .eng_valid(eng_valid), .eng_ready(r_ready), .eng_id(eng_id),
    .eng_cmd(eng_cmd), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_hold, m_id, m_cmd, m_rr, m_ack, m_after_reset;
  int m_served [N];
  int m_cd     [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int consumed, w, c, dirs, fire, nbits, i;
    bit load;
    consumed = -1; load = 0; w = -1;
    if (r_reset) begin
      m_hold = 0; m_id = 0; m_cmd = 0; m_rr = N - 1; m_ack = -1; m_after_reset = 1;
      for (int k = 0; k < N; k++) begin m_served[k] = 0; m_cd[k] = 0; end
      return;
    end
    m_after_reset = 0;
    if (m_hold != 0) begin
      if (r_ready) begin
        consumed = m_id; load = (m_cmd >= 16); m_hold = 0; m_rr = m_id;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        i = (m_rr + k) % N;
        if (w < 0 && r_req[i] && m_served[i] == 0) w = i;
      end
      if (w >= 0) begin
        c = int'(r_cmd[5*w +: 5]);
        dirs = c % 16; fire = c / 16; nbits = 0;
        for (int b = 0; b < 4; b++) if (((dirs >> b) & 1) != 0) nbits++;
        if (nbits > 1) dirs = 0;
        if (m_cd[w] != 0) fire = 0;
        c = fire * 16 + dirs;
        if (c != 0) begin m_hold = 1; m_id = w; m_cmd = c; end
        else consumed = w;
      end
    end
    if (r_tick) begin
      for (int k = 0; k < N; k++) begin
        m_served[k] = 0;
        if (m_cd[k] > 0) m_cd[k] = m_cd[k] - 1;
      end
    end
    if (consumed >= 0) begin
      m_served[consumed] = 1;
      if (load) m_cd[consumed] = FC;
    end
    m_ack = consumed;
  endtask

  // One clock: model advances on the edge, DUT compared 1ns later.
  task automatic step();
    logic [3:0] exp_ack;
    @(posedge clk);
    model_update();
    #1;
    exp_ack = (m_ack >= 0) ? 4'(1 << m_ack) : 4'b0000;
    chk("valid", 32'(eng_valid), 32'(m_hold));
    chk("busy",  32'(busy),      32'(m_hold));
    chk("ack",   32'(ack),       32'(exp_ack));
    if (m_hold != 0 || m_after_reset != 0) begin
      chk("eng_id",  32'(eng_id),  32'(m_id));
      chk("eng_cmd", 32'(eng_cmd), 32'(m_cmd));
    end
  endtask

  task automatic do_reset();
    r_reset = 1; r_tick = 0; r_req = '0; r_cmd = '0; r_ready = 1;
    step();
    r_reset = 0;
  endtask

  task automatic do_tick();
    r_tick = 1; step(); r_tick = 0;
  endtask

  typedef struct {
    bit         rst;
    bit         tck;
    logic [3:0] req;
    logic [19:0] cmd;
    bit         rdy;
    bit         v;
    logic [1:0] id;
    logic [4:0] ecmd;
    logic [3:0] eack;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [4:0] c5;
    // Round-robin sweep of four up-moves, then a frame tick reopens the window.
    tbl[0]  = '{1, 0, 4'h0, 20'h0,     1, 0, 2'd0, 5'h00, 4'h0};
    tbl[1]  = '{0, 0, 4'hF, {4{5'h04}}, 1, 1, 2'd0, 5'h04, 4'h0};
    tbl[2]  = '{0, 0, 4'hF, {4{5'h04}}, 1, 0, 2'd0, 5'h00, 4'h1};
    tbl[3]  = '{0, 0, 4'hF, {4{5'h04}}, 1, 1, 2'd1, 5'h04, 4'h0};
    tbl[4]  = '{0, 0, 4'hF, {4{5'h04}}, 1, 0, 2'd0, 5'h00, 4'h2};
    tbl[5]  = '{0, 0, 4'hF, {4{5'h04}}, 1, 1, 2'd2, 5'h04, 4'h0};
    tbl[6]  = '{0, 0, 4'hF, {4{5'h04}}, 1, 0, 2'd0, 5'h00, 4'h4};
    tbl[7]  = '{0, 0, 4'hF, {4{5'h04}}, 1, 1, 2'd3, 5'h04, 4'h0};
    tbl[8]  = '{0, 0, 4'hF, {4{5'h04}}, 1, 0, 2'd0, 5'h00, 4'h8};
    tbl[9]  = '{0, 0, 4'hF, {4{5'h04}}, 1, 0, 2'd0, 5'h00, 4'h0};
    tbl[10] = '{0, 0, 4'hF, {4{5'h04}}, 1, 0, 2'd0, 5'h00, 4'h0};
    tbl[11] = '{0, 1, 4'hF, {4{5'h04}}, 1, 0, 2'd0, 5'h00, 4'h0};
    tbl[12] = '{0, 0, 4'hF, {4{5'h04}}, 1, 1, 2'd0, 5'h04, 4'h0};

    r_reset = 1; r_tick = 0; r_req = '0; r_cmd = '0; r_ready = 1;

    // Test 1: table vectors.
    for (int n = 0; n < 13; n++) begin
      r_reset = tbl[n].rst; r_tick = tbl[n].tck; r_req = tbl[n].req;
      r_cmd = tbl[n].cmd; r_ready = tbl[n].rdy;
      step();
      chk($sformatf("tbl%0d_valid", n), 32'(eng_valid), 32'(tbl[n].v));
      chk($sformatf("tbl%0d_ack", n),   32'(ack),       32'(tbl[n].eack));
      if (tbl[n].v || tbl[n].rst) begin
        chk($sformatf("tbl%0d_id", n),  32'(eng_id),  32'(tbl[n].id));
        chk($sformatf("tbl%0d_cmd", n), 32'(eng_cmd), 32'(tbl[n].ecmd));
      end
    end

    // Test 2: fire cooldown masking and expiry.
    do_reset();
    r_req = 4'b0100; r_cmd = '0; r_cmd[14:10] = 5'b10010; r_ready = 1;
    step(); chk("t2_first_cmd", 32'(eng_cmd), 32'h12);
    step(); chk("t2_first_ack", 32'(ack), 32'h4);
    step(); step();
    do_tick();
    step(); chk("t2_masked_cmd", 32'(eng_cmd), 32'h02);
    chk("t2_masked_valid", 32'(eng_valid), 32'h1);
    step();
    r_req = 4'b0000;
    for (int t = 0; t < 6; t++) begin do_tick(); step(); end
    r_req = 4'b0100;
    step(); chk("t2_cd1_masked", 32'(eng_cmd), 32'h02);
    step();
    do_tick();
    step(); chk("t2_fire_back", 32'(eng_cmd), 32'h12);
    step();

    // Test 3: two-direction command is dropped but acknowledged.
    do_reset();
    r_req = 4'b0010; r_cmd = '0; r_cmd[9:5] = 5'b00101;
    step(); chk("t3_ack", 32'(ack), 32'h2); chk("t3_novalid", 32'(eng_valid), 32'h0);
    step(); chk("t3_ack_once", 32'(ack), 32'h0); chk("t3_novalid2", 32'(eng_valid), 32'h0);

    // Test 4: stall with changing inputs.
    do_reset();
    r_req = 4'b0001; r_cmd = '0; r_cmd[4:0] = 5'b01000; r_ready = 0;
    step();
    for (int t = 0; t < 10; t++) begin
      r_cmd = 20'($urandom); r_req = 4'($urandom);
      step();
      chk("t4_hold_id", 32'(eng_id), 32'h0);
      chk("t4_hold_cmd", 32'(eng_cmd), 32'h08);
    end
    r_ready = 1;
    step(); chk("t4_xfer_ack", 32'(ack), 32'h1);

    // Test 5: tick coinciding with tank 3's transfer.
    do_reset();
    r_req = 4'hF; r_cmd = {4{5'b00001}}; r_ready = 1;
    for (int t = 0; t < 7; t++) step();
    chk("t5_id3", 32'(eng_id), 32'h3);
    r_tick = 1; step(); r_tick = 0;
    chk("t5_ack3", 32'(ack), 32'h8);
    step(); chk("t5_regrant0", 32'(eng_id), 32'h0);
    step(); step(); chk("t5_regrant1", 32'(eng_id), 32'h1);
    step(); step(); chk("t5_regrant2", 32'(eng_id), 32'h2);
    step(); step(); chk("t5_no3", 32'(eng_valid), 32'h0);

    // Test 6: reset during ISSUE.
    do_reset();
    r_req = 4'b0110; r_cmd = {4{5'b10100}}; r_ready = 1;
    step(); step();
    r_ready = 0;
    step(); chk("t6_issue2", 32'(eng_id), 32'h2);
    r_reset = 1; step(); r_reset = 0;
    chk("t6_valid_off", 32'(eng_valid), 32'h0); chk("t6_no_ack", 32'(ack), 32'h0);
    step(); chk("t6_lowest", 32'(eng_id), 32'h1); chk("t6_fire_ok", 32'(eng_cmd), 32'h14);

    // Randomized run against the model.
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      r_reset = ($urandom_range(0, 299) == 0);
      r_tick  = ($urandom_range(0, 7) == 0);
      r_ready = ($urandom_range(0, 9) < 7);
      r_req   = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        c5[4] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) < 7) c5[3:0] = 4'(1 << $urandom_range(0, 3));
        else                          c5[3:0] = 4'($urandom_range(0, 15));
        r_cmd[5*i +: 5] = c5;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
